fetch_controller: RTL and testbench

Sequences the synchronous-read instruction memory (64 × 32-bit, one-cycle read latency) for the 32-bit processor. Owns the program counter, issues one fetch address per cycle, delivers fetched words to the decode stage over a valid/ready handshake with a one-entry skid buffer, and applies absolute redirects (branch/jump) from execute with in-flight squash. Sits between the instruction memory block and decode.

---
 rtl/fetch_ctrl_pkg.sv | 22 ++
 rtl/fetch_controller_if.sv | 45 ++++
 rtl/fetch_skid_buf.sv | 69 ++++++
 rtl/fetch_controller.sv | 160 ++++++++++++++++
 tb/tb_fetch_controller.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction fetch controller:
//   - fetch_state_e : controller states (IDLE, RUN, HALT)
//   - HALT_WORD     : instruction encoding that parks the controller when the
//                     FETCH_CTRL_HALT_EN build option is enabled
//   - AWIDTH_DEF / RWIDTH_DEF : default address / instruction word widths
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int AWIDTH_DEF = 6;
    localparam int RWIDTH_DEF = 32;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// ---------------------------------------------------------------------------
// fetch_controller_if
// Bundles the fetch controller's memory, decode and redirect signals.
//   start            : one-cycle pulse that starts fetching from address 0
//   mem_addr         : read address to the synchronous instruction memory
//   instr_in         : memory data for the address issued the previous cycle
//   instr_out/_pc    : instruction and its address towards decode
//   instr_valid      : instr_out/instr_pc valid
//   instr_ready      : decode accepts (transfer on valid & ready)
//   redirect_req     : load redirect_target as the next fetch address
//   redirect_target  : absolute redirect address
//   redirect_ack     : high in the cycle a redirect is taken
//   halted           : controller parked in HALT
// Modports: master = fetch controller, slave = memory/decode/execute side.
// ---------------------------------------------------------------------------
interface fetch_controller_if
    import fetch_ctrl_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int RWIDTH = RWIDTH_DEF
) ();

    logic              start;
    logic [AWIDTH-1:0] mem_addr;
    logic [RWIDTH-1:0] instr_in;
    logic [RWIDTH-1:0] instr_out;
    logic [AWIDTH-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_req;
    logic [AWIDTH-1:0] redirect_target;
    logic              redirect_ack;
    logic              halted;

    modport master (
        input  start, instr_in, instr_ready, redirect_req, redirect_target,
        output mem_addr, instr_out, instr_pc, instr_valid, redirect_ack, halted
    );

    modport slave (
        output start, instr_in, instr_ready, redirect_req, redirect_target,
        input  mem_addr, instr_out, instr_pc, instr_valid, redirect_ack, halted
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry hold register for a fetched word and its address. Catches the
// word returning from memory when decode stalls, so the fetch pipe never
// loses data.
//   clk, rst   : clock, synchronous active-high reset (clears full flag)
//   capture    : load cap_data/cap_pc, mark full
//   drain      : entry consumed by decode, mark empty
//   flush      : discard entry (redirect / halt); dominates capture/drain
//   full       : entry valid
//   hold_data  : held instruction word
//   hold_pc    : address of the held word
// ---------------------------------------------------------------------------
module fetch_skid_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int RWIDTH = RWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              drain,
    input  logic              flush,
    input  logic [RWIDTH-1:0] cap_data,
    input  logic [AWIDTH-1:0] cap_pc,
    output logic              full,
    output logic [RWIDTH-1:0] hold_data,
    output logic [AWIDTH-1:0] hold_pc
);

    logic              full_q, full_d;
    logic [RWIDTH-1:0] data_q, data_d;
    logic [AWIDTH-1:0] pc_q,   pc_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (capture) begin
            full_d = 1'b1;
            data_d = cap_data;
            pc_d   = cap_pc;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload is qualified by full_q, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        pc_q   <= pc_d;
    end

    assign full      = full_q;
    assign hold_data = data_q;
    assign hold_pc   = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
// Drives the synchronous-read instruction memory (one-cycle latency), owns
// the program counter, hands fetched words to decode over valid/ready with a
// one-entry skid buffer, and applies absolute redirects with squash of any
// in-flight or held word.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_controller_if.master (memory, decode and redirect signals)
// Build option: FETCH_CTRL_HALT_EN -- when defined, transferring HALT_WORD
// parks the controller in HALT until a redirect or reset; when undefined,
// HALT_WORD is an ordinary instruction and halted is tied low.
// ---------------------------------------------------------------------------
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int RWIDTH = RWIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    fetch_controller_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [AWIDTH-1:0] issued_pc_q, issued_pc_d;

    logic              hold_full;
    logic [RWIDTH-1:0] hold_data;
    logic [AWIDTH-1:0] hold_pc;
    logic              hold_capture, hold_drain, hold_flush;
    logic              issue_ok;

    fetch_skid_buf #(
        .AWIDTH (AWIDTH),
        .RWIDTH (RWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .capture   (hold_capture),
        .drain     (hold_drain),
        .flush     (hold_flush),
        .cap_data  (bus.instr_in),
        .cap_pc    (issued_pc_q),
        .full      (hold_full),
        .hold_data (hold_data),
        .hold_pc   (hold_pc)
    );

    // Output mux: held word has priority over the word returning from memory.
    always_comb begin
        bus.instr_valid = 1'b0;
        bus.instr_out   = '0;
        bus.instr_pc    = '0;
        if (hold_full) begin
            bus.instr_valid = 1'b1;
            bus.instr_out   = hold_data;
            bus.instr_pc    = hold_pc;
        end else if (inflight_q) begin
            bus.instr_valid = 1'b1;
            bus.instr_out   = bus.instr_in;
            bus.instr_pc    = issued_pc_q;
        end
    end

    assign bus.mem_addr     = pc_q;
    assign bus.redirect_ack = bus.redirect_req & ~rst;

    // A new fetch may go out only if its returning word is guaranteed a home:
    // the hold register is empty and the current in-flight word leaves now.
    assign issue_ok = ~hold_full & (~inflight_q | bus.instr_ready);

`ifdef FETCH_CTRL_HALT_EN
    logic halt_hit;
    assign halt_hit = bus.instr_valid & bus.instr_ready &
                      (bus.instr_out == RWIDTH'(HALT_WORD));
    assign bus.halted = (state_q == HALT);
`else
    assign bus.halted = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inflight_d   = inflight_q;
        issued_pc_d  = issued_pc_q;
        hold_capture = 1'b0;
        hold_drain   = 1'b0;
        hold_flush   = 1'b0;

        if (bus.redirect_req) begin
            // Redirect wins in every state; anything fetched so far is stale.
            state_d    = RUN;
            pc_d       = bus.redirect_target;
            inflight_d = 1'b0;
            hold_flush = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d    = RUN;
                        pc_d       = '0;
                        inflight_d = 1'b0;
                    end
                end
                RUN: begin
`ifdef FETCH_CTRL_HALT_EN
                    if (halt_hit) begin
                        state_d    = HALT;
                        inflight_d = 1'b0;
                        hold_flush = 1'b1;
                    end else
`endif
                    begin
                        hold_capture = inflight_q & ~hold_full & ~bus.instr_ready;
                        hold_drain   = hold_full & bus.instr_ready;
                        if (issue_ok) begin
                            inflight_d  = 1'b1;
                            issued_pc_d = pc_q;
                            pc_d        = pc_q + AWIDTH'(1);
                        end else begin
                            // In-flight word was either consumed or captured.
                            inflight_d = 1'b0;
                        end
                    end
                end
`ifdef FETCH_CTRL_HALT_EN
                HALT: begin
                    state_d = HALT;
                end
`endif
                default: begin
                    state_d    = IDLE;
                    inflight_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Only meaningful while inflight_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        issued_pc_q <= issued_pc_d;
    end

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
// Directed bench for fetch_controller. Memory model holds 0x1000 + address
// (mem[5] is overwritten with the halt word for the halt scenario).
// ---------------------------------------------------------------------------
module tb_fetch_controller;
    import fetch_ctrl_pkg::*;

    localparam int AW = 6;
    localparam int RW = 32;

    logic clk = 1'b0;
    logic rst;

    fetch_controller_if #(.AWIDTH(AW), .RWIDTH(RW)) bus ();

    fetch_controller #(.AWIDTH(AW), .RWIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] mem [64];

    always_ff @(posedge clk) begin
        bus.instr_in <= mem[bus.mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clk);
    endtask

    task automatic check_word(input string tag, input logic [AW-1:0] addr);
        check_val({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check_val({tag, "_out"},   bus.instr_out, 32'h1000 + 32'(addr));
        check_val({tag, "_pc"},    32'(bus.instr_pc), 32'(addr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check_val({tag, "_valid"},    32'(bus.instr_valid), 32'd0);
        check_val({tag, "_out"},      bus.instr_out, 32'd0);
        check_val({tag, "_pc"},       32'(bus.instr_pc), 32'd0);
        check_val({tag, "_ack"},      32'(bus.redirect_ack), 32'd0);
        check_val({tag, "_halted"},   32'(bus.halted), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
        rst                 = 1'b1;
        bus.start           = 1'b0;
        bus.instr_ready     = 1'b1;
        bus.redirect_req    = 1'b0;
        bus.redirect_target = '0;

        // ---- reset ----
        next_cycle();
        next_cycle();
        rst = 1'b0;
        sample_point();
        check_reset_outputs("reset");

        // ---- start: addr 0 issued next cycle, word 0 the cycle after ----
        next_cycle();
        bus.start = 1'b1;
        sample_point();
        check_val("idle_valid", 32'(bus.instr_valid), 32'd0);
        next_cycle();
        bus.start = 1'b0;
        sample_point();
        check_val("start_t1_addr",  32'(bus.mem_addr), 32'd0);
        check_val("start_t1_valid", 32'(bus.instr_valid), 32'd0);
        next_cycle();
        sample_point();
        check_word("start_t2", 6'd0);
        check_val("start_t2_addr", 32'(bus.mem_addr), 32'd1);

        // ---- streaming through the 63 -> 0 wrap, one word per cycle ----
        for (int k = 1; k <= 65; k++) begin
            next_cycle();
            sample_point();
            check_word("stream", 6'(k));
        end
        // word 1 (second lap) on the bus, mem_addr = 2

        // ---- ready low 3 cycles ----
        next_cycle();
        bus.instr_ready = 1'b0;
        sample_point();
        check_word("stall_c1", 6'd2);
        check_val("stall_c1_addr", 32'(bus.mem_addr), 32'd3);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            sample_point();
            check_word("stall_hold", 6'd2);
            check_val("stall_hold_addr", 32'(bus.mem_addr), 32'd3);
        end
        next_cycle();
        bus.instr_ready = 1'b1;
        sample_point();
        check_word("drain", 6'd2);
        next_cycle();
        sample_point();
        check_val("drain_bubble_valid", 32'(bus.instr_valid), 32'd0);
        check_val("drain_bubble_addr",  32'(bus.mem_addr), 32'd3);
        next_cycle();
        sample_point();
        check_word("after_drain_a", 6'd3);
        next_cycle();
        sample_point();
        check_word("after_drain_b", 6'd4);
        check_val("after_drain_addr", 32'(bus.mem_addr), 32'd5);

        // ---- redirect to 0x20 while hold full ----
        next_cycle();
        bus.instr_ready = 1'b0;
        sample_point();
        check_word("pre_redir_capture", 6'd5);
        next_cycle();
        bus.redirect_req    = 1'b1;
        bus.redirect_target = 6'h20;
        sample_point();
        check_word("pre_redir_hold", 6'd5);
        check_val("redir_ack", 32'(bus.redirect_ack), 32'd1);
        next_cycle();
        bus.redirect_req = 1'b0;
        bus.instr_ready  = 1'b1;
        sample_point();
        check_val("redir_t1_valid", 32'(bus.instr_valid), 32'd0);
        check_val("redir_t1_addr",  32'(bus.mem_addr), 32'h20);
        check_val("redir_t1_ack",   32'(bus.redirect_ack), 32'd0);
        next_cycle();
        sample_point();
        check_word("redir_t2", 6'h20);
        next_cycle();
        sample_point();
        check_word("redir_t3", 6'h21);

        // ---- halt word at address 5 ----
        mem[5] = HALT_WORD;
        next_cycle();
        bus.redirect_req    = 1'b1;
        bus.redirect_target = 6'd3;
        sample_point();
        next_cycle();
        bus.redirect_req = 1'b0;
        sample_point();
        check_val("h_redir_valid", 32'(bus.instr_valid), 32'd0);
        next_cycle();
        sample_point();
        check_word("h_w3", 6'd3);
        next_cycle();
        sample_point();
        check_word("h_w4", 6'd4);
        next_cycle();
        sample_point();
        check_val("h_w5_out", bus.instr_out, HALT_WORD);
        check_val("h_w5_pc",  32'(bus.instr_pc), 32'd5);
        next_cycle();
        sample_point();
`ifdef FETCH_CTRL_HALT_EN
        check_val("halt_halted", 32'(bus.halted), 32'd1);
        check_val("halt_valid",  32'(bus.instr_valid), 32'd0);
`else
        check_val("nohalt_halted", 32'(bus.halted), 32'd0);
        check_word("nohalt_w6", 6'd6);
`endif
        next_cycle();
        bus.redirect_req    = 1'b1;
        bus.redirect_target = 6'h10;
        sample_point();
`ifdef FETCH_CTRL_HALT_EN
        check_val("halt_hold_halted", 32'(bus.halted), 32'd1);
        check_val("halt_hold_valid",  32'(bus.instr_valid), 32'd0);
`else
        check_word("nohalt_w7", 6'd7);
`endif
        check_val("h_exit_ack", 32'(bus.redirect_ack), 32'd1);
        next_cycle();
        bus.redirect_req = 1'b0;
        sample_point();
        check_val("h_exit_halted", 32'(bus.halted), 32'd0);
        check_val("h_exit_valid",  32'(bus.instr_valid), 32'd0);
        check_val("h_exit_addr",   32'(bus.mem_addr), 32'h10);
        next_cycle();
        sample_point();
        check_word("h_resume", 6'h10);

        // ---- reset mid-stream with hold full ----
        next_cycle();
        bus.instr_ready = 1'b0;
        sample_point();
        check_word("rst_capture", 6'h11);
        next_cycle();
        rst = 1'b1;
        sample_point();
        check_word("rst_hold", 6'h11);
        next_cycle();
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        sample_point();
        check_reset_outputs("midrst");
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            sample_point();
            check_val("idle_no_fetch_valid", 32'(bus.instr_valid), 32'd0);
            check_val("idle_no_fetch_addr",  32'(bus.mem_addr), 32'd0);
        end
        next_cycle();
        bus.start = 1'b1;
        sample_point();
        next_cycle();
        bus.start = 1'b0;
        sample_point();
        check_val("restart_valid", 32'(bus.instr_valid), 32'd0);
        next_cycle();
        sample_point();
        check_word("restart_w0", 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
